// File: rtl/filter_read_controller.sv
// -----------------------------------------------------------------------------
// filter_read_controller
//
// Sequences the filter read address generator through every filter of a layer.
// For each pass it steps the element index `i`, the `is_second_filter` select
// and `current_filter_start_addr`. Normal mode reads one filter per group.
// Interleaved mode reads a filter pair per group, alternating the two filters
// element by element. Each read is offered with read_valid and advances only
// when read_ready accepts it.
//
// Ports
//   clk                        rising-edge clock
//   rst                        synchronous active-high reset
//   start                      one-cycle pass request, sampled only in IDLE
//   base_addr                  start address of the first filter (latched)
//   filter_size                elements per filter (latched)
//   num_groups                 groups to read (latched)
//   interleaved_mode           pairwise interleaved read order (latched)
//   read_ready                 downstream accepts the current read
//   read_valid                 index/select/address form a valid read
//   current_filter_start_addr  start address of the current group
//   i                          element index within the filter
//   is_second_filter           selects the odd filter of an interleaved pair
//   group_last                 marks the last read of a group
//   busy                       high outside IDLE
//   done                       one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module filter_read_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int I_WIDTH    = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [I_WIDTH-1:0]    filter_size,
  input  logic [CNT_WIDTH-1:0]  num_groups,
  input  logic                  interleaved_mode,
  input  logic                  read_ready,
  output logic                  read_valid,
  output logic [ADDR_WIDTH-1:0] current_filter_start_addr,
  output logic [I_WIDTH-1:0]    i,
  output logic                  is_second_filter,
  output logic                  group_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_t;

  state_t                r_state;

  // Configuration captured at start; inputs may change freely during a pass.
  logic [I_WIDTH-1:0]    r_size;
  logic [CNT_WIDTH-1:0]  r_groups;
  logic                  r_mode;

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [I_WIDTH-1:0]    r_i;
  logic                  r_sec;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic [I_WIDTH-1:0]    w_size_m1;
  logic                  w_end_of_i;
  logic                  w_group_wrap;
  logic                  w_pass_end;
  logic [ADDR_WIDTH-1:0] w_stride;
  logic [I_WIDTH-1:0]    w_next_i;
  logic                  w_next_sec;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [CNT_WIDTH-1:0]  w_next_cnt;
  logic                  w_next_last;

  assign w_accept = r_valid && read_ready;

  // Next read position, evaluated every cycle and committed only on acceptance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next_i    = r_i;
    w_next_sec  = r_sec;
    w_next_addr = r_addr;
    w_next_cnt  = r_cnt;

    // r_size is never zero while in READ, so size-1 cannot underflow there.
    w_size_m1  = r_size - I_WIDTH'(1);
    w_end_of_i = (r_i == w_size_m1);

    // Group stride: one filter, or a filter pair, formed at address width so
    // the doubling cannot overflow the narrow size field.
    w_stride = r_mode ? (ADDR_WIDTH'(r_size) << 1) : ADDR_WIDTH'(r_size);

    // The current read closes its group; this equals the registered group_last.
    w_group_wrap = w_end_of_i && (!r_mode || r_sec);
    w_pass_end   = w_group_wrap && (r_cnt == r_groups - CNT_WIDTH'(1));

    if (r_mode && !r_sec) begin
      // First filter of the pair: switch to its partner at the same index.
      w_next_sec = 1'b1;
    end else begin
      w_next_sec = 1'b0;
      if (!w_end_of_i) begin
        w_next_i = r_i + I_WIDTH'(1);
      end else begin
        w_next_i    = '0;
        w_next_addr = r_addr + w_stride;
        w_next_cnt  = r_cnt + CNT_WIDTH'(1);
      end
    end

    // group_last is registered, so it is predicted from the next position.
    w_next_last = (w_next_i == w_size_m1) && (!r_mode || w_next_sec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state  <= ST_IDLE;
      r_size   <= '0;
      r_groups <= '0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_i      <= '0;
      r_sec    <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_size   <= filter_size;
            r_groups <= num_groups;
            r_mode   <= interleaved_mode;
            r_busy   <= 1'b1;
            if ((filter_size == '0) || (num_groups == '0)) begin
              // Empty pass: report completion without issuing any read.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
              r_i     <= '0;
              r_sec   <= 1'b0;
              r_addr  <= base_addr;
              r_cnt   <= '0;
              r_valid <= 1'b1;
              // Only a one-element filter in normal mode ends its group on
              // the very first read.
              r_last  <= (filter_size == I_WIDTH'(1)) && !interleaved_mode;
            end
          end
        end

        ST_READ: begin
          if (w_accept) begin
            // Position advances even on the final read so the last address
            // remains visible after the pass.
            r_i    <= w_next_i;
            r_sec  <= w_next_sec;
            r_addr <= w_next_addr;
            r_cnt  <= w_next_cnt;
            if (w_pass_end) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_last <= w_next_last;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign read_valid                = r_valid;
  assign current_filter_start_addr = r_addr;
  assign i                         = r_i;
  assign is_second_filter          = r_sec;
  assign group_last                = r_last;
  assign busy                      = r_busy;
  assign done                      = r_done;

endmodule

// File: tb/tb_filter_read_controller.sv
// -----------------------------------------------------------------------------
// Testbench for filter_read_controller.
// Stimulus issues passes; a reference model expands each pass into its full
// list of expected reads plus a completion marker and queues them. A monitor
// pops and compares on every accepted read and every done pulse, and checks
// that outputs hold while a read is stalled.
// -----------------------------------------------------------------------------
module tb_filter_read_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [3:0]  filter_size = '0;
  logic [7:0]  num_groups = '0;
  logic        interleaved_mode = 1'b0;
  logic        read_ready = 1'b1;
  logic        read_valid;
  logic [15:0] cur_addr;
  logic [3:0]  idx;
  logic        sec;
  logic        group_last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_done;
    logic [15:0] addr;
    logic [3:0]  i;
    logic        sec;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_final_addr;

  bit ready_rand  = 1'b0;
  bit ready_force = 1'b1;

  filter_read_controller #(
    .ADDR_WIDTH(16),
    .I_WIDTH   (4),
    .CNT_WIDTH (8)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .base_addr                (base_addr),
    .filter_size              (filter_size),
    .num_groups               (num_groups),
    .interleaved_mode         (interleaved_mode),
    .read_ready               (read_ready),
    .read_valid               (read_valid),
    .current_filter_start_addr(cur_addr),
    .i                        (idx),
    .is_second_filter         (sec),
    .group_last               (group_last),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  // Single driver of read_ready, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    read_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass is every group, every element, and (interleaved)
  // both filters of the pair at each element, in that nesting order.
  task automatic model_pass(input logic [15:0] b, input logic [3:0] s,
                            input logic [7:0] g, input logic m);
    exp_t        it;
    logic [15:0] stride;
    int          nsel;
    stride = m ? 16'(s) * 16'd2 : 16'(s);
    nsel   = m ? 2 : 1;
    for (int gi = 0; gi < int'(g); gi++) begin
      for (int e = 0; e < int'(s); e++) begin
        for (int k = 0; k < nsel; k++) begin
          it.is_done = 1'b0;
          it.addr    = b + 16'(gi) * stride;
          it.i       = 4'(e);
          it.sec     = (k == 1);
          it.last    = (e == int'(s) - 1) && (k == nsel - 1);
          exp_q.push_back(it);
        end
      end
    end
    it.is_done = 1'b1;
    it.addr    = '0;
    it.i       = '0;
    it.sec     = 1'b0;
    it.last    = 1'b0;
    exp_q.push_back(it);
    exp_final_addr = b + 16'(g) * stride;
  endtask

  // Monitor / scoreboard.
  bit          exp_done_next = 1'b0;
  bit          have_prev = 1'b0;
  logic [15:0] prev_addr;
  logic [3:0]  prev_i;
  logic        prev_sec;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_done_next = 1'b0;
      have_prev     = 1'b0;
    end else begin
      if (exp_done_next) begin
        check("done_after_last_read", done, 1);
        exp_done_next = 1'b0;
      end
      if (have_prev) begin
        check("stall_hold_valid", read_valid, 1);
        check("stall_hold_addr", cur_addr, prev_addr);
        check("stall_hold_i", idx, prev_i);
        check("stall_hold_sec", sec, prev_sec);
        check("stall_hold_last", group_last, prev_last);
        have_prev = 1'b0;
      end
      if (done) begin
        check("done_expected", (exp_q.size() > 0) && exp_q[0].is_done, 1);
        check("done_valid_low", read_valid, 0);
        if ((exp_q.size() > 0) && exp_q[0].is_done) void'(exp_q.pop_front());
      end
      if (read_valid && read_ready) begin
        check("read_expected", (exp_q.size() > 0) && !exp_q[0].is_done, 1);
        if ((exp_q.size() > 0) && !exp_q[0].is_done) begin
          exp_t it;
          it = exp_q.pop_front();
          check("read_addr", cur_addr, it.addr);
          check("read_i", idx, it.i);
          check("read_sec", sec, it.sec);
          check("read_group_last", group_last, it.last);
          if ((exp_q.size() > 0) && exp_q[0].is_done) exp_done_next = 1'b1;
        end
      end else if (read_valid) begin
        have_prev = 1'b1;
        prev_addr = cur_addr;
        prev_i    = idx;
        prev_sec  = sec;
        prev_last = group_last;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_read_valid"}, read_valid, 0);
    check({tag, "_addr"}, cur_addr, 0);
    check({tag, "_i"}, idx, 0);
    check({tag, "_sec"}, sec, 0);
    check({tag, "_group_last"}, group_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Issue one start; config inputs are scrambled right after to show they are
  // latched. Checks the first-cycle response in cycle N+1.
  task automatic start_pass(input logic [15:0] b, input logic [3:0] s,
                            input logic [7:0] g, input logic m);
    bit zero;
    zero = (s == 0) || (g == 0);
    model_pass(b, s, g, m);
    @(posedge clk);
    #1;
    base_addr        = b;
    filter_size      = s;
    num_groups       = g;
    interleaved_mode = m;
    start            = 1'b1;
    @(posedge clk);
    #1;
    start            = 1'b0;
    base_addr        = 16'($urandom);
    filter_size      = 4'($urandom);
    num_groups       = 8'($urandom);
    interleaved_mode = 1'($urandom);
    @(negedge clk);
    if (zero) begin
      check("zero_done_n1", done, 1);
      check("zero_busy_n1", busy, 1);
      check("zero_valid_n1", read_valid, 0);
    end else begin
      check("first_valid_n1", read_valid, 1);
      check("first_i_n1", idx, 0);
      check("first_addr_n1", cur_addr, b);
    end
  endtask

  task automatic finish_pass(input bit zero);
    int n;
    n = 0;
    if (zero) begin
      @(negedge clk);
      check("zero_busy_n2", busy, 0);
      check("zero_done_n2", done, 0);
      check("zero_valid_n2", read_valid, 0);
    end
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("pass_within_budget", n < 1000, 1);
    check("queue_drained", exp_q.size(), 0);
    if (!zero) begin
      check("final_addr", cur_addr, exp_final_addr);
      check("final_i", idx, 0);
      check("final_sec", sec, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Normal mode walk-through.
    start_pass(16'h0100, 4'd3, 8'd2, 1'b0);
    finish_pass(1'b0);

    // Interleaved pair; final address must be 0x44.
    start_pass(16'h0040, 4'd2, 8'd1, 1'b1);
    finish_pass(1'b0);

    // Stall for three cycles with i=2 presented.
    start_pass(16'h0200, 4'd4, 8'd1, 1'b0);
    @(negedge clk);
    check("stall_setup_i", idx, 1);
    ready_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_i", idx, 2);
      check("stall_valid", read_valid, 1);
    end
    ready_force = 1'b1;
    finish_pass(1'b0);

    // Degenerate configurations.
    start_pass(16'h0700, 4'd3, 8'd0, 1'b0);
    finish_pass(1'b1);
    start_pass(16'h0700, 4'd0, 8'd5, 1'b1);
    finish_pass(1'b1);

    // Reset during the second group, then restart from a new base.
    start_pass(16'h0300, 4'd3, 8'd3, 1'b0);
    n = 0;
    while (cur_addr != 16'h0303 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_second_group", n < 100, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midpass_reset");
    start_pass(16'h0500, 4'd2, 8'd2, 1'b1);
    finish_pass(1'b0);

    // Wrap-around with an ignored start pulse during READ.
    start_pass(16'hFFFE, 4'd2, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    base_addr   = 16'h1234;
    filter_size = 4'd3;
    num_groups  = 8'd1;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_pass(1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_queued_start_busy", busy, 0);
    end

    // Randomized passes with random back-pressure.
    ready_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      logic [15:0] rb;
      logic [3:0]  rs;
      logic [7:0]  rg;
      logic        rm;
      rb = 16'($urandom);
      rs = 4'($urandom_range(1, 5));
      rg = 8'($urandom_range(1, 3));
      rm = 1'($urandom_range(0, 1));
      start_pass(rb, rs, rg, rm);
      finish_pass(1'b0);
    end
    ready_rand = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
